account_responder: RTL and testbench

ACCOUNT_RESPONDER -- requirements
Module: account_responder

---
 rtl/account_responder.sv | 156 +++++++++++++++
 tb/tb_account_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/account_responder.sv
// Card/password account table with a sequential search, replying VERIFY/UPDATE requests over valid/ready.
// Optional per-entry lockout after three consecutive bad passwords is enabled by defining ACCT_LOCKOUT_EN.
module account_responder #(
    parameter int CARD_WIDTH     = 6,
    parameter int PASSWORD_WIDTH = 16,
    parameter int BALANCE_WIDTH  = 20,
    parameter int NUM_ACCOUNTS   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [CARD_WIDTH-1:0]     req_card,
    input  logic [PASSWORD_WIDTH-1:0] req_password,
    input  logic [BALANCE_WIDTH-1:0]  req_balance,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [1:0]                resp_status,
    output logic [BALANCE_WIDTH-1:0]  resp_balance
);
    localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCOUNTS - 1);

    localparam logic [1:0] OP_VERIFY = 2'b00;
    localparam logic [1:0] OP_UPDATE = 2'b01;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_NOT_FOUND = 2'b01;
    localparam logic [1:0] ST_BAD_PSW   = 2'b10;
    localparam logic [1:0] ST_LOCKED    = 2'b11;

    typedef enum logic [1:0] {IDLE, SEARCH, RESPOND} state_t;

    state_t                    state;
    logic [1:0]                op_q;
    logic [CARD_WIDTH-1:0]     card_q;
    logic [PASSWORD_WIDTH-1:0] psw_q;
    logic [BALANCE_WIDTH-1:0]  bal_q;
    logic [IDX_W-1:0]          idx;
    logic                      found;
    logic                      done;

    logic [BALANCE_WIDTH-1:0]  bal_tab [NUM_ACCOUNTS];
`ifdef ACCT_LOCKOUT_EN
    logic [1:0]                fail_cnt [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0]   locked;
`endif

    // Card numbers and passwords are fixed functions of the entry index, so only balances are stored.
    logic                      op_known;
    logic                      card_hit;
    logic                      psw_ok;
    logic                      entry_locked;

    always_comb begin
        op_known = (op_q == OP_VERIFY) || (op_q == OP_UPDATE);
        card_hit = op_known && (card_q == CARD_WIDTH'(idx) + CARD_WIDTH'(1));
        psw_ok   = (psw_q == PASSWORD_WIDTH'(16'h1000) + PASSWORD_WIDTH'(idx));
`ifdef ACCT_LOCKOUT_EN
        entry_locked = locked[idx];
`else
        entry_locked = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_status  <= ST_OK;
            resp_balance <= '0;
            op_q         <= '0;
            card_q       <= '0;
            psw_q        <= '0;
            bal_q        <= '0;
            idx          <= '0;
            found        <= 1'b0;
            done         <= 1'b0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal_tab[i] <= BALANCE_WIDTH'(1000 * (i + 1));
`ifdef ACCT_LOCKOUT_EN
                fail_cnt[i] <= 2'd0;
                locked[i]   <= 1'b0;
`endif
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        card_q    <= req_card;
                        psw_q     <= req_password;
                        bal_q     <= req_balance;
                        idx       <= '0;
                        found     <= 1'b0;
                        done      <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    // One compare cycle per entry, then a single resolve cycle that commits the result.
                    if (!done) begin
                        if (card_hit) begin
                            done  <= 1'b1;
                            found <= 1'b1;
                        end else if (idx == LAST_IDX) begin
                            done <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        state        <= RESPOND;
                        resp_valid   <= 1'b1;
                        resp_status  <= ST_NOT_FOUND;
                        resp_balance <= '0;
                        if (found) begin
                            if (entry_locked) begin
                                resp_status <= ST_LOCKED;
                            end else if (!psw_ok) begin
                                resp_status <= ST_BAD_PSW;
`ifdef ACCT_LOCKOUT_EN
                                if (fail_cnt[idx] != 2'd3) fail_cnt[idx] <= fail_cnt[idx] + 2'd1;
                                if (fail_cnt[idx] == 2'd2) locked[idx] <= 1'b1;
`endif
                            end else begin
                                resp_status <= ST_OK;
`ifdef ACCT_LOCKOUT_EN
                                fail_cnt[idx] <= 2'd0;
`endif
                                if (op_q == OP_UPDATE) begin
                                    bal_tab[idx] <= bal_q;
                                    resp_balance <= bal_q;
                                end else begin
                                    resp_balance <= bal_tab[idx];
                                end
                            end
                        end
                    end
                end
                RESPOND: begin
                    if (resp_ready) begin
                        state        <= IDLE;
                        req_ready    <= 1'b1;
                        resp_valid   <= 1'b0;
                        resp_status  <= ST_OK;
                        resp_balance <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_account_responder.sv
// Directed bench for account_responder: latency, status/balance, back-pressure, reset abort, lockout.
module tb_account_responder;
    localparam int CW = 6;
    localparam int PW = 16;
    localparam int BW = 20;
    localparam int NA = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [CW-1:0] req_card = '0;
    logic [PW-1:0] req_password = '0;
    logic [BW-1:0] req_balance = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [1:0]    resp_status;
    logic [BW-1:0] resp_balance;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    account_responder #(
        .CARD_WIDTH(CW), .PASSWORD_WIDTH(PW), .BALANCE_WIDTH(BW), .NUM_ACCOUNTS(NA)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_card(req_card), .req_password(req_password), .req_balance(req_balance),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_balance(resp_balance)
    );

    // Issues one request from IDLE, returns edges from accept to resp_valid (-1 on timeout).
    task automatic run_req(input logic [1:0] op, input logic [CW-1:0] card, input logic [PW-1:0] psw,
                           input logic [BW-1:0] bal, output int lat, output logic [1:0] st,
                           output logic [BW-1:0] b);
        req_op = op; req_card = card; req_password = psw; req_balance = bal;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; st = 2'bxx; b = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin lat = i; break; end
        end
        if (lat > 0) begin
            st = resp_status; b = resp_balance;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_handshake got ready/valid=%b want 10", {req_ready, resp_valid});
        end
        n_checks++;
        if (resp_status !== 2'b00) begin
            n_fail++; $display("FAIL reset_status got %b want 00", resp_status);
        end
        n_checks++;
        if (resp_balance !== '0) begin
            n_fail++; $display("FAIL reset_balance got %0d want 0", resp_balance);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_verify;
        int lat; logic [1:0] st; logic [BW-1:0] b;
        run_req(2'b00, 6'd3, 16'h1002, '0, lat, st, b);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL verify3_latency got %0d want 4", lat); end
        n_checks++;
        if (st !== 2'b00 || b !== BW'(3000)) begin
            n_fail++; $display("FAIL verify3_result got st=%b bal=%0d want st=00 bal=3000", st, b);
        end
        run_req(2'b00, 6'd1, 16'h1000, '0, lat, st, b);
        n_checks++;
        if (lat !== 2 || st !== 2'b00 || b !== BW'(1000)) begin
            n_fail++; $display("FAIL verify1 got lat=%0d st=%b bal=%0d want lat=2 st=00 bal=1000", lat, st, b);
        end
        run_req(2'b00, 6'd8, 16'h1007, '0, lat, st, b);
        n_checks++;
        if (lat !== 9 || st !== 2'b00 || b !== BW'(8000)) begin
            n_fail++; $display("FAIL verify8 got lat=%0d st=%b bal=%0d want lat=9 st=00 bal=8000", lat, st, b);
        end
    endtask

    task automatic test_not_found;
        int lat; logic [1:0] st; logic [BW-1:0] b;
        run_req(2'b00, 6'd9, 16'h1008, '0, lat, st, b);
        n_checks++;
        if (lat !== 9 || st !== 2'b01 || b !== '0) begin
            n_fail++; $display("FAIL verify9_nf got lat=%0d st=%b bal=%0d want lat=9 st=01 bal=0", lat, st, b);
        end
        run_req(2'b11, 6'd2, 16'h1001, BW'(55), lat, st, b);
        n_checks++;
        if (lat !== 9 || st !== 2'b01 || b !== '0) begin
            n_fail++; $display("FAIL op11_nf got lat=%0d st=%b bal=%0d want lat=9 st=01 bal=0", lat, st, b);
        end
        run_req(2'b10, 6'd2, 16'h1001, BW'(66), lat, st, b);
        n_checks++;
        if (lat !== 9 || st !== 2'b01) begin
            n_fail++; $display("FAIL op10_nf got lat=%0d st=%b want lat=9 st=01", lat, st);
        end
        run_req(2'b00, 6'd2, 16'h1001, '0, lat, st, b);
        n_checks++;
        if (st !== 2'b00 || b !== BW'(2000)) begin
            n_fail++; $display("FAIL reserved_nowrite got st=%b bal=%0d want st=00 bal=2000", st, b);
        end
    endtask

    task automatic test_bad_psw;
        int lat; logic [1:0] st; logic [BW-1:0] b;
        run_req(2'b00, 6'd5, 16'h1234, '0, lat, st, b);
        n_checks++;
        if (lat !== 6 || st !== 2'b10 || b !== '0) begin
            n_fail++; $display("FAIL bad_psw5 got lat=%0d st=%b bal=%0d want lat=6 st=10 bal=0", lat, st, b);
        end
        run_req(2'b01, 6'd7, 16'h0000, BW'(9), lat, st, b);
        run_req(2'b00, 6'd7, 16'h1006, '0, lat, st, b);
        n_checks++;
        if (st !== 2'b00 || b !== BW'(7000)) begin
            n_fail++; $display("FAIL bad_psw_nowrite got st=%b bal=%0d want st=00 bal=7000", st, b);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        req_op = 2'b00; req_card = 6'd4; req_password = 16'h1003;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin lat = i; break; end
        end
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL bp_latency got %0d want 5", lat); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({resp_valid, req_ready, resp_status, resp_balance} !== {1'b1, 1'b0, 2'b00, BW'(4000)}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v=%b rdy=%b st=%b bal=%0d want v=1 rdy=0 st=00 bal=4000",
                         c, resp_valid, req_ready, resp_status, resp_balance);
            end
        end
        // New request waits alongside the completing response.
        req_card = 6'd1; req_password = 16'h1000; req_valid = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL bp_release got ready/valid=%b want 10", {req_ready, resp_valid});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL next_accept got req_ready=%b want 0", req_ready);
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin lat = i; break; end
        end
        n_checks++;
        if (lat !== 2 || resp_status !== 2'b00 || resp_balance !== BW'(1000)) begin
            n_fail++;
            $display("FAIL b2b_result got lat=%0d st=%b bal=%0d want lat=2 st=00 bal=1000", lat, resp_status, resp_balance);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_update;
        int lat; logic [1:0] st; logic [BW-1:0] b;
        run_req(2'b01, 6'd1, 16'h1000, BW'(250), lat, st, b);
        n_checks++;
        if (lat !== 2 || st !== 2'b00 || b !== BW'(250)) begin
            n_fail++; $display("FAIL update1 got lat=%0d st=%b bal=%0d want lat=2 st=00 bal=250", lat, st, b);
        end
        run_req(2'b00, 6'd1, 16'h1000, '0, lat, st, b);
        n_checks++;
        if (st !== 2'b00 || b !== BW'(250)) begin
            n_fail++; $display("FAIL update1_readback got st=%b bal=%0d want st=00 bal=250", st, b);
        end
        run_req(2'b01, 6'd8, 16'h1007, 20'hFFFFF, lat, st, b);
        n_checks++;
        if (st !== 2'b00 || b !== 20'hFFFFF) begin
            n_fail++; $display("FAIL update8_max got st=%b bal=%h want st=00 bal=fffff", st, b);
        end
    endtask

    task automatic test_lockout;
        int lat; logic [1:0] st; logic [BW-1:0] b;
        for (int k = 0; k < 3; k++) begin
            run_req(2'b00, 6'd2, 16'hBEEF, '0, lat, st, b);
            n_checks++;
            if (lat !== 3 || st !== 2'b10) begin
                n_fail++; $display("FAIL lock_bad%0d got lat=%0d st=%b want lat=3 st=10", k, lat, st);
            end
        end
        run_req(2'b00, 6'd2, 16'h1001, '0, lat, st, b);
`ifdef ACCT_LOCKOUT_EN
        n_checks++;
        if (st !== 2'b11 || b !== '0) begin
            n_fail++; $display("FAIL lock_locked got st=%b bal=%0d want st=11 bal=0", st, b);
        end
`else
        n_checks++;
        if (st !== 2'b00 || b !== BW'(2000)) begin
            n_fail++; $display("FAIL nolock_ok got st=%b bal=%0d want st=00 bal=2000", st, b);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_req(2'b00, 6'd2, 16'h1001, '0, lat, st, b);
        n_checks++;
        if (st !== 2'b00 || b !== BW'(2000)) begin
            n_fail++; $display("FAIL lock_after_reset got st=%b bal=%0d want st=00 bal=2000", st, b);
        end
        run_req(2'b00, 6'd1, 16'h1000, '0, lat, st, b);
        n_checks++;
        if (b !== BW'(1000)) begin
            n_fail++; $display("FAIL reset_restores_bal got bal=%0d want 1000", b);
        end
    endtask

    task automatic test_reset_abort;
        int lat; logic [1:0] st; logic [BW-1:0] b;
        req_op = 2'b01; req_card = 6'd6; req_password = 16'h1005; req_balance = BW'(77);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL abort_state got ready/valid=%b want 10", {req_ready, resp_valid});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_req(2'b00, 6'd6, 16'h1005, '0, lat, st, b);
        n_checks++;
        if (st !== 2'b00 || b !== BW'(6000)) begin
            n_fail++; $display("FAIL abort_nowrite got st=%b bal=%0d want st=00 bal=6000", st, b);
        end
    endtask

    initial begin
        test_reset();
        test_verify();
        test_not_found();
        test_bad_psw();
        test_back_to_back();
        test_update();
        test_lockout();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
